// File: rtl/interrupt_control_pkg.sv
// Shared state encodings and interrupt IOT codes
// for the CPU interrupt control slice.
package interrupt_control_pkg;

  typedef enum logic [4:0] {
    S_F0, S_F1, S_F2, S_F3,
    S_D0, S_D1, S_D2, S_D3,
    S_DW,
    S_E0, S_E1, S_E2, S_E3,
    S_H0, S_H1, S_H2, S_H3,
    S_EAE0, S_EAE1, S_EAE2,
    S_EAE3, S_EAE4, S_EAE5,
    S_DB0, S_DB1
  } state_e;

  localparam logic [0:2] OP_JMS = 3'o4;
  localparam logic [0:2] OP_JMP = 3'o5;
  localparam logic [0:2] OP_IOT = 3'o6;

  localparam logic [0:11] IOT_SKON = 12'o6000;
  localparam logic [0:11] IOT_ION  = 12'o6001;
  localparam logic [0:11] IOT_IOF  = 12'o6002;
  localparam logic [0:11] IOT_SRQ  = 12'o6003;
  localparam logic [0:11] IOT_RTF  = 12'o6005;
  localparam logic [0:11] IOT_CAF  = 12'o6007;

  localparam logic [0:5] CIF_HI = 6'o62;

  // CIF/CDI: 62x2 and 62x3
  function automatic logic is_cif(
    input logic [0:11] ins
  );
    return (ins[0:5] == CIF_HI) &&
           (ins[9:10] == 2'b01);
  endfunction

endpackage

// File: rtl/interrupt_control_irq_collector.sv
// Masks, OR-reduces and registers device
// interrupt requests into a single int_req.
module interrupt_control_irq_collector #(
  parameter int              N_DEV    = 4,
  parameter logic [N_DEV-1:0] IRQ_MASK = {N_DEV{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_DEV-1:0] dev_irq,
  output logic             int_req
);

  always_ff @(posedge clk) begin
    if (reset) begin
      int_req <= 1'b0;
    end else begin
      int_req <= |(dev_irq & IRQ_MASK);
    end
  end

endmodule

// File: rtl/interrupt_control.sv
// Interrupt enable/inhibit/skip logic feeding
// the CPU sequencer's interrupt inputs.
module interrupt_control
  import interrupt_control_pkg::*;
#(
  parameter int              N_DEV    = 4,
  parameter logic [N_DEV-1:0] IRQ_MASK = {N_DEV{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       state,
  input  logic [0:11]      instruction,
  input  logic             int_in_prog,
  input  logic [N_DEV-1:0] dev_irq,
  output logic             int_req,
  output logic             int_ena,
  output logic             int_inh,
  output logic             ion_pend,
  output logic             iot_skip,
  output logic             int_ack
);

  logic       iip_q;
  logic       take;
  logic [0:2] op;
  logic       jmp_jms;
  logic       in_f0, in_f1, in_f2, in_dw;
  logic       is_skon, is_ion, is_iof;
  logic       is_srq, is_rtf, is_caf;
  logic       is_cifd, is_djmp, is_ijmp;

  interrupt_control_irq_collector #(
    .N_DEV    (N_DEV),
    .IRQ_MASK (IRQ_MASK)
  ) u_irq_collector (
    .clk     (clk),
    .reset   (reset),
    .dev_irq (dev_irq),
    .int_req (int_req)
  );

  assign op      = instruction[0:2];
  assign jmp_jms = (op == OP_JMS) ||
                   (op == OP_JMP);

  assign in_f0 = (state == S_F0);
  assign in_f1 = (state == S_F1);
  assign in_f2 = (state == S_F2);
  assign in_dw = (state == S_DW);

  assign is_skon = (instruction == IOT_SKON);
  assign is_ion  = (instruction == IOT_ION);
  assign is_iof  = (instruction == IOT_IOF);
  assign is_srq  = (instruction == IOT_SRQ);
  assign is_rtf  = (instruction == IOT_RTF);
  assign is_caf  = (instruction == IOT_CAF);
  assign is_cifd = (op == OP_IOT) &&
                   is_cif(instruction);
  assign is_djmp = jmp_jms && !instruction[3];
  assign is_ijmp = jmp_jms && instruction[3];

  // Edge of int_in_prog so a repeated E0 does not re-ack
  assign take = int_in_prog && !iip_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      iip_q    <= 1'b0;
      int_ack  <= 1'b0;
      int_ena  <= 1'b0;
      int_inh  <= 1'b0;
      ion_pend <= 1'b0;
      iot_skip <= 1'b0;
    end else begin
      iip_q   <= int_in_prog;
      int_ack <= take;
      unique case (1'b1)
        in_f0: iot_skip <= 1'b0;
        in_f1: begin
          if (ion_pend) begin
            int_ena  <= 1'b1;
            ion_pend <= 1'b0;
          end
        end
        in_f2: begin
          unique case (1'b1)
            is_skon: begin
              iot_skip <= int_ena;
              int_ena  <= 1'b0;
              ion_pend <= 1'b0;
            end
            is_ion: ion_pend <= 1'b1;
            is_iof: begin
              int_ena  <= 1'b0;
              ion_pend <= 1'b0;
            end
            is_srq: iot_skip <= int_req;
            is_rtf: begin
              ion_pend <= 1'b1;
              int_inh  <= 1'b1;
            end
            is_caf: begin
              int_ena  <= 1'b0;
              int_inh  <= 1'b0;
              ion_pend <= 1'b0;
            end
            is_cifd: int_inh <= 1'b1;
            is_djmp: int_inh <= 1'b0;
            default: ;
          endcase
        end
        in_dw: begin
          if (is_ijmp) int_inh <= 1'b0;
        end
        default: ;
      endcase
      // Acceptance overrides any same-cycle enable
      if (take) begin
        int_ena  <= 1'b0;
        ion_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_interrupt_control.sv
// Self-checking bench for interrupt_control:
// vector table, corner sequences, random vs model.
module tb_interrupt_control;
  import interrupt_control_pkg::*;

  localparam logic [3:0] MASK  = 4'b1111;
  localparam logic [3:0] MASK2 = 4'b0111;

  logic        clk = 1'b0;
  logic        reset;
  state_e      state;
  logic [0:11] instruction;
  logic        int_in_prog;
  logic [3:0]  dev_irq;
  logic        int_req, int_ena, int_inh;
  logic        ion_pend, iot_skip, int_ack;
  logic        req2, ena2, inh2, pend2;
  logic        skip2, ack2;

  logic [11:0] cur_ins;
  int vectors = 0;
  int miscompares = 0;

  bit m_req, m_ena, m_inh, m_pend;
  bit m_skip, m_ack, m_prev;

  always #5 clk = ~clk;

  interrupt_control #(
    .N_DEV(4), .IRQ_MASK(MASK)
  ) dut (
    .clk(clk), .reset(reset),
    .state(state), .instruction(instruction),
    .int_in_prog(int_in_prog), .dev_irq(dev_irq),
    .int_req(int_req), .int_ena(int_ena),
    .int_inh(int_inh), .ion_pend(ion_pend),
    .iot_skip(iot_skip), .int_ack(int_ack)
  );

  interrupt_control #(
    .N_DEV(4), .IRQ_MASK(MASK2)
  ) dut2 (
    .clk(clk), .reset(reset),
    .state(state), .instruction(instruction),
    .int_in_prog(int_in_prog), .dev_irq(dev_irq),
    .int_req(req2), .int_ena(ena2),
    .int_inh(inh2), .ion_pend(pend2),
    .iot_skip(skip2), .int_ack(ack2)
  );

  typedef struct {
    bit          rst;
    state_e      st;
    logic [11:0] ins;
    bit          iip;
    logic [3:0]  irq;
    logic [5:0]  exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input bit rst, input state_e st,
    input logic [11:0] ins, input bit iip,
    input logic [3:0] irq, input logic [5:0] exp
  );
    vec_t v;
    v.rst = rst; v.st = st; v.ins = ins;
    v.iip = iip; v.irq = irq; v.exp = exp;
    return v;
  endfunction

  function automatic logic [5:0] outs();
    return {int_req, int_ena, int_inh,
            ion_pend, iot_skip, int_ack};
  endfunction

  // Reference: rules applied to the cycle's inputs
  task automatic model_step();
    int  op;
    int  lo;
    bit  ibit, take;
    bit  n_ena, n_inh, n_pend, n_skip;
    op   = int'(cur_ins) / 512;
    lo   = int'(cur_ins) % 8;
    ibit = cur_ins[8];
    take = int_in_prog && !m_prev;
    if (reset) begin
      m_req = 0; m_ena = 0; m_inh = 0; m_pend = 0;
      m_skip = 0; m_ack = 0; m_prev = 0;
      return;
    end
    n_ena = m_ena; n_inh = m_inh;
    n_pend = m_pend; n_skip = m_skip;
    if (state == S_F0) n_skip = 0;
    if (state == S_F1 && m_pend) begin
      n_ena = 1; n_pend = 0;
    end
    if (state == S_F2) begin
      case (cur_ins)
        12'o6000: begin
          n_skip = m_ena; n_ena = 0; n_pend = 0;
        end
        12'o6001: n_pend = 1;
        12'o6002: begin n_ena = 0; n_pend = 0; end
        12'o6003: n_skip = m_req;
        12'o6005: begin n_pend = 1; n_inh = 1; end
        12'o6007: begin
          n_ena = 0; n_inh = 0; n_pend = 0;
        end
        default: begin
          if (int'(cur_ins) / 64 == 'o62 &&
              (lo == 2 || lo == 3)) n_inh = 1;
          if ((op == 4 || op == 5) && !ibit)
            n_inh = 0;
        end
      endcase
    end
    if (state == S_DW && (op == 4 || op == 5) && ibit)
      n_inh = 0;
    if (take) begin n_ena = 0; n_pend = 0; end
    m_req  = (dev_irq & MASK) != 0;
    m_ack  = take;
    m_prev = int_in_prog;
    m_ena = n_ena; m_inh = n_inh;
    m_pend = n_pend; m_skip = n_skip;
  endtask

  task automatic cyc(
    input bit r, input state_e s,
    input logic [11:0] ins, input bit ip,
    input logic [3:0] irq
  );
    reset = r; state = s; cur_ins = ins;
    instruction = ins; int_in_prog = ip;
    dev_irq = irq;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(
    input string name, input logic act,
    input logic exp
  );
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b want %b",
               name, act, exp);
    end
  endtask

  task automatic run_ion(input logic [3:0] irq);
    cyc(0, S_F0, 12'o6001, 0, irq);
    cyc(0, S_F1, 12'o6001, 0, irq);
    cyc(0, S_F2, 12'o6001, 0, irq);
    cyc(0, S_F3, 12'o6001, 0, irq);
  endtask

  initial begin
    reset = 1; state = S_F0; cur_ins = '0;
    instruction = '0; int_in_prog = 0;
    dev_irq = '0;

    // {req, ena, inh, pend, skip, ack}
    tbl.push_back(mk(1, S_F0, 12'o0000, 0, 4'h0, 6'b000000));
    tbl.push_back(mk(0, S_F0, 12'o6001, 0, 4'h0, 6'b000000));
    tbl.push_back(mk(0, S_F1, 12'o6001, 0, 4'h0, 6'b000000));
    tbl.push_back(mk(0, S_F2, 12'o6001, 0, 4'h4, 6'b100100));
    tbl.push_back(mk(0, S_F3, 12'o6001, 0, 4'h4, 6'b100100));
    tbl.push_back(mk(0, S_F0, 12'o7200, 0, 4'h4, 6'b100100));
    tbl.push_back(mk(0, S_F1, 12'o7200, 0, 4'h4, 6'b110000));
    tbl.push_back(mk(0, S_F2, 12'o7200, 0, 4'h4, 6'b110000));
    tbl.push_back(mk(0, S_F3, 12'o7200, 0, 4'h4, 6'b110000));
    tbl.push_back(mk(0, S_E0, 12'o7200, 1, 4'h4, 6'b100001));
    tbl.push_back(mk(0, S_E0, 12'o7200, 1, 4'h4, 6'b100000));
    tbl.push_back(mk(0, S_E1, 12'o7200, 1, 4'h4, 6'b100000));
    tbl.push_back(mk(0, S_F0, 12'o6001, 0, 4'h4, 6'b100000));
    tbl.push_back(mk(0, S_F1, 12'o6001, 0, 4'h4, 6'b100000));
    tbl.push_back(mk(0, S_F2, 12'o6001, 0, 4'h4, 6'b100100));
    tbl.push_back(mk(0, S_F3, 12'o6001, 0, 4'h4, 6'b100100));
    tbl.push_back(mk(0, S_F0, 12'o6002, 0, 4'h4, 6'b100100));
    tbl.push_back(mk(0, S_F1, 12'o6002, 0, 4'h4, 6'b110000));
    tbl.push_back(mk(0, S_F2, 12'o6002, 0, 4'h4, 6'b100000));
    tbl.push_back(mk(0, S_F3, 12'o6002, 0, 4'h4, 6'b100000));

    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].st, tbl[i].ins,
          tbl[i].iip, tbl[i].irq);
      vectors++;
      if (outs() !== tbl[i].exp) begin
        miscompares++;
        $display("FAIL tbl[%0d]: got %b want %b",
                 i, outs(), tbl[i].exp);
      end
    end

    // CIF then direct JMP, interrupt after the JMP
    cyc(1, S_F0, 12'o0000, 0, 4'h4);
    run_ion(4'h4);
    cyc(0, S_F0, 12'o6212, 0, 4'h4);
    cyc(0, S_F1, 12'o6212, 0, 4'h4);
    cyc(0, S_F2, 12'o6212, 0, 4'h4);
    chk("cif_inh_set", int_inh, 1);
    cyc(0, S_F3, 12'o6212, 0, 4'h4);
    cyc(0, S_F0, 12'o5200, 0, 4'h4);
    cyc(0, S_F1, 12'o5200, 0, 4'h4);
    cyc(0, S_F2, 12'o5200, 0, 4'h4);
    chk("jmp_inh_clr", int_inh, 0);
    chk("jmp_ena", int_ena, 1);
    chk("jmp_req", int_req, 1);
    cyc(0, S_F3, 12'o5200, 0, 4'h4);
    cyc(0, S_E0, 12'o5200, 1, 4'h4);
    chk("jmp_ack", int_ack, 1);
    chk("jmp_ack_ena", int_ena, 0);

    // Indirect JMP clears inhibit at DW only
    cyc(0, S_F0, 12'o6213, 0, 4'h0);
    cyc(0, S_F1, 12'o6213, 0, 4'h0);
    cyc(0, S_F2, 12'o6213, 0, 4'h0);
    chk("cdi_inh_set", int_inh, 1);
    cyc(0, S_F3, 12'o6213, 0, 4'h0);
    cyc(0, S_F0, 12'o5410, 0, 4'h0);
    cyc(0, S_F1, 12'o5410, 0, 4'h0);
    cyc(0, S_F2, 12'o5410, 0, 4'h0);
    chk("jmpi_f2_hold", int_inh, 1);
    cyc(0, S_F3, 12'o5410, 0, 4'h0);
    cyc(0, S_D0, 12'o5410, 0, 4'h0);
    cyc(0, S_DW, 12'o5410, 0, 4'h0);
    chk("jmpi_dw_clr", int_inh, 0);

    // SKON with IE=1 then IE=0
    cyc(1, S_F0, 12'o0000, 0, 4'h0);
    run_ion(4'h0);
    cyc(0, S_F0, 12'o6000, 0, 4'h0);
    cyc(0, S_F1, 12'o6000, 0, 4'h0);
    chk("skon_pre_ena", int_ena, 1);
    cyc(0, S_F2, 12'o6000, 0, 4'h0);
    chk("skon_skip1", iot_skip, 1);
    chk("skon_ena_clr", int_ena, 0);
    cyc(0, S_F3, 12'o6000, 0, 4'h0);
    chk("skon_skip_f3", iot_skip, 1);
    cyc(0, S_F0, 12'o7000, 0, 4'h0);
    chk("skon_skip_f0", iot_skip, 0);
    cyc(0, S_F1, 12'o6000, 0, 4'h0);
    cyc(0, S_F2, 12'o6000, 0, 4'h0);
    chk("skon_ie0", iot_skip, 0);

    // SRQ with no request, then bit 3 under both masks
    cyc(1, S_F0, 12'o0000, 0, 4'h0);
    cyc(0, S_F0, 12'o6003, 0, 4'h0);
    cyc(0, S_F1, 12'o6003, 0, 4'h0);
    cyc(0, S_F2, 12'o6003, 0, 4'h0);
    chk("srq_none", iot_skip, 0);
    cyc(0, S_F3, 12'o6003, 0, 4'h8);
    cyc(0, S_F0, 12'o6003, 0, 4'h8);
    cyc(0, S_F1, 12'o6003, 0, 4'h8);
    cyc(0, S_F2, 12'o6003, 0, 4'h8);
    chk("srq_irq3", iot_skip, 1);
    chk("srq_masked", skip2, 0);
    chk("req_masked", req2, 0);

    // IOF cancels a pending enable
    cyc(1, S_F0, 12'o0000, 0, 4'h0);
    cyc(0, S_F2, 12'o6001, 0, 4'h0);
    chk("ion_pend", ion_pend, 1);
    cyc(0, S_F2, 12'o6002, 0, 4'h0);
    chk("iof_pend_clr", ion_pend, 0);
    cyc(0, S_F1, 12'o7000, 0, 4'h0);
    chk("iof_no_ena", int_ena, 0);

    // RTF then reset during E1
    cyc(1, S_F0, 12'o0000, 0, 4'h0);
    cyc(0, S_F0, 12'o6005, 0, 4'h0);
    cyc(0, S_F1, 12'o6005, 0, 4'h0);
    cyc(0, S_F2, 12'o6005, 0, 4'h0);
    chk("rtf_pend", ion_pend, 1);
    chk("rtf_inh", int_inh, 1);
    cyc(0, S_F3, 12'o6005, 0, 4'h0);
    cyc(0, S_E0, 12'o6005, 0, 4'h0);
    cyc(1, S_E1, 12'o6005, 0, 4'h0);
    chk("rst_ena", int_ena, 0);
    chk("rst_inh", int_inh, 0);
    chk("rst_pend", ion_pend, 0);
    chk("rst_skip", iot_skip, 0);
    chk("rst_ack", int_ack, 0);

    // Randomised run against the reference model
    begin
      logic [11:0] codes [14];
      bit          ip;
      codes = '{12'o6000, 12'o6001, 12'o6002,
                12'o6003, 12'o6005, 12'o6007,
                12'o6212, 12'o6213, 12'o6203,
                12'o5200, 12'o5410, 12'o4100,
                12'o4410, 12'o7200};
      ip = 0;
      cyc(1, S_F0, 12'o0000, 0, 4'h0);
      for (int n = 0; n < 3000; n++) begin
        state_e      s;
        logic [11:0] ins;
        logic [3:0]  irq;
        bit          r;
        logic [5:0]  exp;
        r = ($urandom % 64) == 0;
        if ($urandom % 4 != 0)
          s = state_e'($urandom_range(0, 3));
        else
          s = state_e'($urandom_range(0, 24));
        if ($urandom % 8 == 0) s = S_DW;
        if ($urandom % 4 == 0)
          ins = 12'($urandom);
        else
          ins = codes[$urandom_range(0, 13)];
        if ($urandom % 8 == 0) ip = !ip;
        irq = ($urandom % 2 == 0) ? 4'h0
                                  : 4'($urandom);
        cyc(r, s, ins, ip, irq);
        exp = {m_req, m_ena, m_inh,
               m_pend, m_skip, m_ack};
        vectors++;
        if (outs() !== exp) begin
          miscompares++;
          $display("FAIL rand[%0d] st=%0d ins=%o: got %b want %b",
                   n, s, ins, outs(), exp);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
